// File: rtl/gaussian_filter_accel_hls_deadlock_pkg.sv
// Shared definitions for the deadlock report unit: FSM state encoding,
// the index-width helper and the default trace timeout.
package gaussian_filter_accel_hls_deadlock_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRACE   = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;
    localparam logic [1:0] ST_LATCHED = 2'd3;

    localparam int DEFAULT_TRACE_TIMEOUT = 1024;

    // Index width for n processes; a single process still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gaussian_filter_accel_hls_deadlock_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request
// bit and a flag telling whether any bit was set.
module gaussian_filter_accel_hls_deadlock_prio_enc
    import gaussian_filter_accel_hls_deadlock_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = id_width(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gaussian_filter_accel_hls_deadlock_report_unit.sv
// Deadlock report unit: elects an origin from the detect units, traces the
// token around the dependence cycle, pulses token_clear on its return and
// holds one report on a valid/ready port until accepted, then stays latched.
// Define GAUSSIAN_FILTER_ACCEL_HLS_DEADLOCK_TIMESTAMP_EN to stamp the report
// with a free-running cycle counter sampled at election; otherwise the
// timestamp reads 0.
module gaussian_filter_accel_hls_deadlock_report_unit
    import gaussian_filter_accel_hls_deadlock_pkg::*;
#(
    parameter  int PROC_NUM      = 4,
    parameter  int TRACE_TIMEOUT = DEFAULT_TRACE_TIMEOUT,
    parameter  int CNT_W         = 16,
    localparam int ID_W          = id_width(PROC_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_out_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [ID_W-1:0]     report_origin_id,
    output logic [PROC_NUM-1:0] report_proc_mask,
    output logic [CNT_W-1:0]    report_cycle_len,
    output logic [31:0]         report_timestamp,
    output logic [CNT_W-1:0]    abort_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_LEN = CNT_W'(TRACE_TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [PROC_NUM-1:0] mask_q;
    logic [CNT_W-1:0]    len_q;
    logic [PROC_NUM-1:0] origin_q;
    logic                clear_q;
    logic [CNT_W-1:0]    abort_q;
    logic [ID_W-1:0]     rep_id_q;
    logic [PROC_NUM-1:0] rep_mask_q;
    logic [CNT_W-1:0]    rep_len_q;

    logic [ID_W-1:0]     elect_idx;
    logic                elect_valid;
    logic [PROC_NUM-1:0] elect_onehot;
    logic                start, returned, timed_out;
    logic [CNT_W-1:0]    len_inc;

    gaussian_filter_accel_hls_deadlock_prio_enc #(.N(PROC_NUM)) u_elect (
        .req_i   (dl_detect_out_vec),
        .idx_o   (elect_idx),
        .valid_o (elect_valid)
    );

    // Election, return and timeout conditions for the current cycle.
    always_comb begin
        elect_onehot            = '0;
        elect_onehot[elect_idx] = 1'b1;
        start     = (state_q == ST_IDLE) && elect_valid;
        returned  = (state_q == ST_TRACE) && dl_detect_out_vec[id_q];
        timed_out = (state_q == ST_TRACE) && (len_q == TIMEOUT_LEN);
        len_inc   = (&len_q) ? len_q : len_q + 1'b1;
    end

    // Next-state logic; a return beats a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (elect_valid) state_d = ST_TRACE;
            ST_TRACE:   if (returned) state_d = ST_REPORT;
                        else if (timed_out) state_d = ST_IDLE;
            ST_REPORT:  if (report_ready) state_d = ST_LATCHED;
            ST_LATCHED: state_d = ST_LATCHED;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, trace bookkeeping, pulses, abort counter and report capture.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            origin_q   <= '0;
            clear_q    <= 1'b0;
            abort_q    <= '0;
            rep_id_q   <= '0;
            rep_mask_q <= '0;
            rep_len_q  <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= start ? elect_onehot : '0;
            clear_q  <= returned;
            if (start) begin
                id_q   <= elect_idx;
                mask_q <= elect_onehot;
                len_q  <= '0;
            end else if (state_q == ST_TRACE) begin
                mask_q <= mask_q | token_seen_vec;
                len_q  <= len_inc;
            end
            if (returned) begin
                rep_id_q   <= id_q;
                rep_mask_q <= mask_q | token_seen_vec;
                rep_len_q  <= len_inc;
            end
            if (timed_out && !returned && !(&abort_q)) begin
                abort_q <= abort_q + 1'b1;
            end
        end
    end

`ifdef GAUSSIAN_FILTER_ACCEL_HLS_DEADLOCK_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_hold_q;
    logic [31:0] rep_ts_q;

    // Free-running cycle counter, sampled at election and frozen on return.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q      <= '0;
            ts_hold_q <= '0;
            rep_ts_q  <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (start)    ts_hold_q <= ts_q;
            if (returned) rep_ts_q  <= ts_hold_q;
        end
    end

    assign report_timestamp = rep_ts_q;
`else
    assign report_timestamp = 32'd0;
`endif

    assign dl_detect_in     = (state_q != ST_IDLE);
    assign origin           = origin_q;
    assign token_clear      = clear_q;
    assign report_valid     = (state_q == ST_REPORT);
    assign report_origin_id = rep_id_q;
    assign report_proc_mask = rep_mask_q;
    assign report_cycle_len = rep_len_q;
    assign abort_count      = abort_q;

endmodule

// File: tb/tb_gaussian_filter_accel_hls_deadlock_report_unit.sv
// Self-checking bench for the deadlock report unit (PROC_NUM=4, timeout 8).
module tb_gaussian_filter_accel_hls_deadlock_report_unit;

    localparam int P    = 4;
    localparam int TO   = 8;
    localparam int CW   = 16;
    localparam int ID_W = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [P-1:0]  dl_out = '0;
    logic [P-1:0]  seen = '0;
    logic          ready = 1'b0;
    logic          dl_in;
    logic [P-1:0]  origin;
    logic          token_clear;
    logic          rvalid;
    logic [ID_W-1:0] rid;
    logic [P-1:0]  rmask;
    logic [CW-1:0] rlen;
    logic [31:0]   rts;
    logic [CW-1:0] aborts;

    int total  = 0;
    int passed = 0;
    int cnt    = 0;

    gaussian_filter_accel_hls_deadlock_report_unit #(
        .PROC_NUM(P), .TRACE_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .dl_detect_out_vec (dl_out),
        .token_seen_vec    (seen),
        .dl_detect_in      (dl_in),
        .origin            (origin),
        .token_clear       (token_clear),
        .report_valid      (rvalid),
        .report_ready      (ready),
        .report_origin_id  (rid),
        .report_proc_mask  (rmask),
        .report_cycle_len  (rlen),
        .report_timestamp  (rts),
        .abort_count       (aborts)
    );

    always #5 clock = ~clock;

    // Expected timestamp for a detect driven while the bench counter reads c.
    function automatic logic [31:0] exp_ts(input int c);
`ifdef GAUSSIAN_FILTER_ACCEL_HLS_DEADLOCK_TIMESTAMP_EN
        return 32'(c);
`else
        return 32'd0;
`endif
    endfunction

    function automatic int lowest(input logic [P-1:0] v);
        for (int i = 0; i < P; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
        cnt++;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        dl_out = '0;
        seen   = '0;
        ready  = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        cnt   = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++;
        if ({dl_in, origin, token_clear, rvalid, rid, rmask, rlen, rts, aborts} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {dl_in, origin, token_clear, rvalid, rid, rmask, rlen, rts, aborts});
        else passed++;
    endtask

    // Origin 2, token seen at 3, 0, 2, return at cycle 5.
    task automatic scenario_one();
        logic [31:0] ts;
        ts = exp_ts(cnt);
        dl_out = 4'b0100;
        cyc();
        total++;
        if (origin !== 4'b0100 || dl_in !== 1'b1)
            $display("FAIL s1_origin: got origin=%b dl_in=%b required 0100/1", origin, dl_in);
        else passed++;
        dl_out = '0;
        cyc();
        total++;
        if (origin !== 4'b0000)
            $display("FAIL s1_origin_pulse: got %b required 0000", origin);
        else passed++;
        seen = 4'b1000; cyc();
        seen = 4'b0001; cyc();
        seen = 4'b0100; cyc();
        seen = 4'b0000; dl_out = 4'b0100;
        total++;
        if (token_clear !== 1'b0)
            $display("FAIL s1_no_early_clear: got %b required 0", token_clear);
        else passed++;
        cyc();
        dl_out = '0;
        total++;
        if ({token_clear, rvalid, rid, rmask, rlen, rts} !== {1'b1, 1'b1, 2'd2, 4'b1101, 16'd5, ts})
            $display("FAIL s1_report: got clr=%b v=%b id=%0d mask=%b len=%0d ts=%0d required 1 1 2 1101 5 %0d",
                     token_clear, rvalid, rid, rmask, rlen, rts, ts);
        else passed++;
        cyc();
        total++;
        if (token_clear !== 1'b0 || rvalid !== 1'b1)
            $display("FAIL s1_clear_pulse: got clr=%b v=%b required 0 1", token_clear, rvalid);
        else passed++;
    endtask

    task automatic test_directed();
        do_reset();
        scenario_one();
    endtask

    task automatic test_priority();
        do_reset();
        dl_out = 4'b1010;
        cyc();
        total++;
        if (origin !== 4'b0010)
            $display("FAIL prio_origin: got %b required 0010", origin);
        else passed++;
        dl_out = 4'b1000;
        cyc();
        cyc();
        total++;
        if (token_clear !== 1'b0 || rvalid !== 1'b0)
            $display("FAIL prio_ignore_bit3: got clr=%b v=%b required 0 0", token_clear, rvalid);
        else passed++;
        dl_out = 4'b0010;
        cyc();
        dl_out = '0;
        total++;
        if ({token_clear, rid, rmask, rlen} !== {1'b1, 2'd1, 4'b0010, 16'd3})
            $display("FAIL prio_report: got clr=%b id=%0d mask=%b len=%0d required 1 1 0010 3",
                     token_clear, rid, rmask, rlen);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        dl_out = 4'b0001;
        cyc();
        dl_out = '0;
        for (int t = 1; t <= TO; t++) begin
            total++;
            if (dl_in !== 1'b1)
                $display("FAIL timeout_hold_%0d: got dl_in=%b required 1", t, dl_in);
            else passed++;
            cyc();
        end
        total++;
        if ({dl_in, aborts, rvalid} !== {1'b0, 16'd1, 1'b0})
            $display("FAIL timeout_abort: got dl_in=%b abort=%0d v=%b required 0 1 0", dl_in, aborts, rvalid);
        else passed++;
        dl_out = 4'b0100;
        cyc();
        dl_out = '0;
        total++;
        if (origin !== 4'b0100 || dl_in !== 1'b1)
            $display("FAIL timeout_reelect: got origin=%b dl_in=%b required 0100 1", origin, dl_in);
        else passed++;
        repeat (TO) cyc();
        total++;
        if (aborts !== 16'd2 || dl_in !== 1'b0)
            $display("FAIL timeout_second: got abort=%0d dl_in=%b required 2 0", aborts, dl_in);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        dl_out = 4'b0001;
        cyc();
        dl_out = '0;
        seen   = 4'b0110;
        cyc();
        seen   = '0;
        dl_out = 4'b0001;
        cyc();
        for (int i = 0; i < 10; i++) begin
            dl_out = 4'($urandom);
            seen   = 4'($urandom);
            total++;
            if ({rvalid, rid, rmask, rlen} !== {1'b1, 2'd0, 4'b0111, 16'd2})
                $display("FAIL bp_hold_%0d: got v=%b id=%0d mask=%b len=%0d required 1 0 0111 2",
                         i, rvalid, rid, rmask, rlen);
            else passed++;
            cyc();
        end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || dl_in !== 1'b1)
            $display("FAIL bp_accept: got v=%b dl_in=%b required 0 1", rvalid, dl_in);
        else passed++;
        dl_out = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if ({origin, dl_in, rvalid, token_clear} !== {4'b0000, 1'b1, 1'b0, 1'b0})
                $display("FAIL latched_%0d: got origin=%b dl_in=%b v=%b clr=%b required 0000 1 0 0",
                         i, origin, dl_in, rvalid, token_clear);
            else passed++;
        end
        dl_out = '0;
    endtask

    task automatic test_reset_mid_trace();
        do_reset();
        dl_out = 4'b0010;
        cyc();
        dl_out = '0;
        cyc();
        cyc();
        total++;
        if (dl_in !== 1'b1)
            $display("FAIL midrst_tracing: got dl_in=%b required 1", dl_in);
        else passed++;
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({dl_in, origin, token_clear, rvalid, rid, rmask, rlen, rts, aborts} !== '0)
            $display("FAIL midrst_outputs: got %h required 0",
                     {dl_in, origin, token_clear, rvalid, rid, rmask, rlen, rts, aborts});
        else passed++;
        @(posedge clock);
        #2;
        reset = 1'b0;
        cnt   = 0;
        scenario_one();
    endtask

    task automatic test_timestamp();
        logic [31:0] ts;
        do_reset();
        repeat (100) cyc();
        ts = exp_ts(cnt);
        dl_out = 4'b1000;
        cyc();
        dl_out = '0;
        cyc();
        dl_out = 4'b1000;
        cyc();
        dl_out = '0;
        total++;
        if (rvalid !== 1'b1 || rts !== ts)
            $display("FAIL timestamp: got v=%b ts=%0d required 1 %0d", rvalid, rts, ts);
        else passed++;
    endtask

    // Random detect vectors, token traffic and return times against a model
    // that only counts trace cycles and ORs the observed tokens.
    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [P-1:0] v, m, s, d;
            logic [31:0]  ts;
            int id, r, last;
            do_reset();
            v = 4'($urandom_range(1, 15));
            id = lowest(v);
            r = $urandom_range(1, TO + 4);
            last = (r <= TO) ? r : TO;
            m = 4'(1) << id;
            ts = exp_ts(cnt);
            dl_out = v;
            cyc();
            total++;
            if (origin !== m)
                $display("FAIL rand%0d_origin: got %b required %b", it, origin, m);
            else passed++;
            for (int t = 1; t <= last; t++) begin
                s = 4'($urandom);
                d = 4'($urandom);
                d[id] = (t == r);
                m |= s;
                seen   = s;
                dl_out = d;
                cyc();
            end
            seen   = '0;
            dl_out = '0;
            total++;
            if (r <= TO) begin
                if ({token_clear, rvalid, rid, rmask, rlen, rts} !==
                    {1'b1, 1'b1, ID_W'(id), m, CW'(r), ts})
                    $display("FAIL rand%0d_report: got clr=%b v=%b id=%0d mask=%b len=%0d ts=%0d required 1 1 %0d %b %0d %0d",
                             it, token_clear, rvalid, rid, rmask, rlen, rts, id, m, r, ts);
                else passed++;
            end else begin
                if ({dl_in, aborts, rvalid, token_clear} !== {1'b0, 16'd1, 1'b0, 1'b0})
                    $display("FAIL rand%0d_abort: got dl_in=%b abort=%0d v=%b clr=%b required 0 1 0 0",
                             it, dl_in, aborts, rvalid, token_clear);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_priority();
        test_timeout();
        test_backpressure();
        test_reset_mid_trace();
        test_timestamp();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
